// File: rtl/pe_operand_seq_if.sv
// Handshake and strobe bundle between one PE's operand sequencer and its feeders/datapath.
// master: the sequencer side; slave: feeders, multiplier and accumulator side.
interface pe_operand_seq_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             reg_load;
  logic             reg_clr;
  logic             mul_start;
  logic             mul_done;
  logic             acc_en;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] elem_idx;
  logic             err;

  modport master (
    input  start, in_valid, mul_done,
    output in_ready, reg_load, reg_clr, mul_start, acc_en, acc_clr, busy, done, elem_idx, err
  );

  modport slave (
    output start, in_valid, mul_done,
    input  in_ready, reg_load, reg_clr, mul_start, acc_en, acc_clr, busy, done, elem_idx, err
  );
endinterface

// File: rtl/pe_operand_seq.sv
// Operand/multiply sequencer for one PE: fetches K_LEN operand pairs, launches the multiplier,
// gates the accumulator. Optional MUL-state watchdog enabled by the PE_SEQ_TIMEOUT_EN macro.
module pe_operand_seq #(
  parameter int unsigned K_LEN       = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic              clk,
  input logic              clr_n,
  pe_operand_seq_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StMul,
    StAcc,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(K_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             mul_first_q, mul_first_d;

  logic tmo_hit;
  logic err_set;
  logic err_clr;
  logic err_o;

  logic in_ready;
  logic reg_load;
  logic reg_clr;
  logic acc_clr;
  logic mul_start;
  logic acc_en;
  logic busy;
  logic done;
  logic mul_ok;

  // mul_done is only meaningful once the multiplier has had a cycle to react.
  assign mul_ok = bus.mul_done & ~mul_first_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mul_first_d = 1'b0;
    in_ready    = 1'b0;
    reg_load    = 1'b0;
    reg_clr     = 1'b0;
    acc_clr     = 1'b0;
    mul_start   = 1'b0;
    acc_en      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StClear;
          idx_d   = '0;
          err_clr = 1'b1;
        end
      end
      StClear: begin
        busy    = 1'b1;
        reg_clr = 1'b1;
        acc_clr = 1'b1;
        idx_d   = '0;
        state_d = StFetch;
      end
      StFetch: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (bus.in_valid) begin
          reg_load    = 1'b1;
          mul_first_d = 1'b1;
          state_d     = StMul;
        end
      end
      StMul: begin
        busy      = 1'b1;
        mul_start = mul_first_q;
        if (mul_ok) begin
          state_d = StAcc;
        end else if (tmo_hit) begin
          err_set = 1'b1;
          state_d = StDone;
        end
      end
      StAcc: begin
        busy   = 1'b1;
        acc_en = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + CNT_W'(1);
          state_d = StFetch;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      mul_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mul_first_q <= mul_first_d;
    end
  end

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            err_q, err_d;

  // tmo_cnt_q holds the number of MUL cycles already spent before the current one.
  assign tmo_hit = (state_q == StMul) && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = (state_q == StMul) ? tmo_cnt_q + TmoW'(1) : '0;
    err_d     = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_cfg;

  assign tmo_hit    = 1'b0;
  assign err_o      = 1'b0;
  assign unused_cfg = ^{TIMEOUT_CYC, err_set, err_clr};
`endif

  assign bus.in_ready  = in_ready;
  assign bus.reg_load  = reg_load;
  assign bus.reg_clr   = reg_clr;
  assign bus.acc_clr   = acc_clr;
  assign bus.mul_start = mul_start;
  assign bus.acc_en    = acc_en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.elem_idx  = idx_q;
  assign bus.err       = err_o;

  a_done_then_idle: assert property (@(posedge clk) disable iff (!clr_n) done |=> !busy);
  a_mul_start_pulse: assert property (@(posedge clk) disable iff (!clr_n)
                                      mul_start |=> !mul_start);
  a_load_in_fetch: assert property (@(posedge clk) disable iff (!clr_n) reg_load |-> in_ready);
  a_acc_idx_range: assert property (@(posedge clk) disable iff (!clr_n)
                                    acc_en |-> (idx_q <= LastIdx));

endmodule

// File: tb/tb_pe_operand_seq.sv
// Bench for pe_operand_seq: table-driven timing runs, directed corner cases and randomized runs,
// all checked cycle by cycle against a phase-list model of the dot-product sequence.
module tb_pe_operand_seq;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  pe_operand_seq_if #(.CNT_W(4)) if0 ();
  pe_operand_seq_if #(.CNT_W(4)) if1 ();

  pe_operand_seq #(.K_LEN(4), .CNT_W(4), .TIMEOUT_CYC(15)) u_dut0 (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (if0)
  );

  pe_operand_seq #(.K_LEN(1), .CNT_W(4), .TIMEOUT_CYC(15)) u_dut1 (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (if1)
  );

  always #5 clk = ~clk;

`ifdef PE_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int Tmo = 15;

  // Output vector layout: busy rdy load rclr aclr mst acc done err
  localparam logic [8:0] EBusy = 9'h100;
  localparam logic [8:0] ERdy  = 9'h080;
  localparam logic [8:0] ELoad = 9'h040;
  localparam logic [8:0] EClr  = 9'h030;
  localparam logic [8:0] EMst  = 9'h008;
  localparam logic [8:0] EAcc  = 9'h004;
  localparam logic [8:0] EDone = 9'h002;

  typedef struct {
    bit         st;
    bit         iv;
    bit         md;
    logic [8:0] exp;
    int         idx;
  } step_t;

  typedef struct {
    int w;
    int stall;
    int dly;
    int exp_done;
    int exp_pulses;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int last_idx[2];
  bit m_err[2];

  function automatic int klen(input int w);
    return (w == 0) ? 4 : 1;
  endfunction

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic bit rs();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic step_t mk(input bit st, input bit iv, input bit md, input logic [8:0] e,
                               input int idx);
    step_t s;
    s.st  = st;
    s.iv  = iv;
    s.md  = md;
    s.exp = e;
    s.idx = idx;
    return s;
  endfunction

  function automatic logic [8:0] get_out(input int w);
    if (w == 0) begin
      return {if0.busy, if0.in_ready, if0.reg_load, if0.reg_clr, if0.acc_clr, if0.mul_start,
              if0.acc_en, if0.done, if0.err};
    end
    return {if1.busy, if1.in_ready, if1.reg_load, if1.reg_clr, if1.acc_clr, if1.mul_start,
            if1.acc_en, if1.done, if1.err};
  endfunction

  function automatic int get_idx(input int w);
    return (w == 0) ? int'(if0.elem_idx) : int'(if1.elem_idx);
  endfunction

  task automatic set_in(input int w, input bit st, input bit iv, input bit md);
    if (w == 0) begin
      if0.start = st; if0.in_valid = iv; if0.mul_done = md;
    end else begin
      if1.start = st; if1.in_valid = iv; if1.mul_done = md;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input int w, input string tag, input step_t q[$], output int done_cyc,
                       output int n_load, output int n_mst, output int n_acc, output int n_done);
    logic [8:0] got;
    int         gidx;
    done_cyc = -1; n_load = 0; n_mst = 0; n_acc = 0; n_done = 0;
    foreach (q[i]) begin
      set_in(w, q[i].st, q[i].iv, q[i].md);
      @(negedge clk);
      got  = get_out(w);
      gidx = get_idx(w);
      n_tests++;
      if (got !== q[i].exp || gidx != q[i].idx) begin
        n_fail++;
        $display("FAIL %s dut%0d cyc %0d: outs=%h idx=%0d, expected outs=%h idx=%0d",
                 tag, w, i, got, gidx, q[i].exp, q[i].idx);
      end
      n_load += int'(got[6]);
      n_mst  += int'(got[3]);
      n_acc  += int'(got[2]);
      n_done += int'(got[1]);
      if (got[1] === 1'b1) done_cyc = i;
      @(posedge clk);
      #1;
    end
    set_in(w, 1'b0, 1'b0, 1'b0);
  endtask

  // Builds the expected cycle sequence of one run from its phase structure, then applies it.
  task automatic run_dot(input int w, input int stall[4], input int dly[4], input bit noise,
                         output int done_cyc, output int n_load, output int n_mst,
                         output int n_acc, output int n_done);
    step_t q[$];
    bit    tmo_out = 1'b0;
    q.push_back(mk(1'b1, noise & rb(), noise & rb(), {8'h0, m_err[w]}, last_idx[w]));
    m_err[w] = 1'b0;
    q.push_back(mk(noise & rs(), noise & rb(), noise & rb(), EBusy | EClr, 0));
    for (int k = 0; k < klen(w) && !tmo_out; k++) begin
      for (int s = 0; s < stall[k]; s++) q.push_back(mk(noise & rs(), 1'b0, noise & rb(),
                                                         EBusy | ERdy, k));
      q.push_back(mk(noise & rs(), 1'b1, noise & rb(), EBusy | ERdy | ELoad, k));
      q.push_back(mk(noise & rs(), noise & rb(), noise & rb(), EBusy | EMst, k));
      last_idx[w] = k;
      if (TmoEn && dly[k] + 1 > Tmo) begin
        for (int j = 0; j < Tmo - 1; j++) q.push_back(mk(noise & rs(), noise & rb(), 1'b0,
                                                          EBusy, k));
        m_err[w] = 1'b1;
        tmo_out  = 1'b1;
      end else begin
        for (int j = 0; j < dly[k] - 1; j++) q.push_back(mk(noise & rs(), noise & rb(), 1'b0,
                                                            EBusy, k));
        q.push_back(mk(noise & rs(), noise & rb(), 1'b1, EBusy, k));
        q.push_back(mk(noise & rs(), noise & rb(), noise & rb(), EBusy | EAcc, k));
      end
    end
    q.push_back(mk(noise & rs(), noise & rb(), noise & rb(), EBusy | EDone | {8'h0, m_err[w]},
                   last_idx[w]));
    apply(w, "run", q, done_cyc, n_load, n_mst, n_acc, n_done);
  endtask

  task automatic idle_cycles(input int w, input int n, input bit noise);
    step_t q[$];
    int    dc, nl, nm, na, nd;
    for (int i = 0; i < n; i++) q.push_back(mk(1'b0, noise & rb(), noise & rb(),
                                                 {8'h0, m_err[w]}, last_idx[w]));
    apply(w, "idle", q, dc, nl, nm, na, nd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   st[4];
    int   dl[4];
    int   dc, nl, nm, na, nd, w;

    vecs[0] = '{0, 0, 1, 18, 4};
    vecs[1] = '{0, 3, 1, 21, 4};
    vecs[2] = '{1, 0, 1, 6, 1};
    vecs[3] = '{1, 0, 1, 6, 1};
    vecs[4] = '{0, 0, 2, 22, 4};
    vecs[5] = '{1, 2, 3, 10, 1};

    set_in(0, 1'b0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0, 1'b0);
    last_idx = '{0, 0};
    m_err    = '{1'b0, 1'b0};

    #2;
    chk("reset_outs0", int'(get_out(0)), 0);
    chk("reset_outs1", int'(get_out(1)), 0);
    chk("reset_idx0", get_idx(0), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    idle_cycles(0, 2, 1'b1);
    idle_cycles(1, 2, 1'b1);

    // Back-to-back table runs; each start lands in the cycle right after the previous done.
    for (int v = 0; v < 6; v++) begin
      st = '{0, 0, 0, 0};
      dl = '{vecs[v].dly, vecs[v].dly, vecs[v].dly, vecs[v].dly};
      st[(vecs[v].w == 0) ? 2 : 0] = vecs[v].stall;
      run_dot(vecs[v].w, st, dl, 1'b0, dc, nl, nm, na, nd);
      chk($sformatf("tbl%0d_done_cyc", v), dc, vecs[v].exp_done);
      chk($sformatf("tbl%0d_loads", v), nl, vecs[v].exp_pulses);
      chk($sformatf("tbl%0d_mul_starts", v), nm, vecs[v].exp_pulses);
      chk($sformatf("tbl%0d_acc_ens", v), na, vecs[v].exp_pulses);
      chk($sformatf("tbl%0d_dones", v), nd, 1);
    end

    // Stray start and mul_done pulses everywhere must not disturb a run.
    run_dot(0, '{0, 0, 0, 0}, '{1, 1, 1, 1}, 1'b1, dc, nl, nm, na, nd);
    chk("noisy_done_cyc", dc, 18);
    chk("noisy_dones", nd, 1);
    chk("noisy_acc_ens", na, 4);

    if (TmoEn) begin
      run_dot(0, '{0, 0, 0, 0}, '{1, 30, 1, 1}, 1'b0, dc, nl, nm, na, nd);
      chk("tmo_done_cyc", dc, 22);
      chk("tmo_acc_ens", na, 1);
      chk("tmo_dones", nd, 1);
      idle_cycles(0, 2, 1'b1);
      run_dot(0, '{0, 0, 0, 0}, '{1, 1, 1, 1}, 1'b0, dc, nl, nm, na, nd);
      chk("tmo_rerun_done_cyc", dc, 18);
    end else begin
      run_dot(0, '{0, 0, 0, 0}, '{1, 20, 1, 1}, 1'b0, dc, nl, nm, na, nd);
      chk("longwait_done_cyc", dc, 37);
      chk("longwait_acc_ens", na, 4);
    end

    for (int r = 0; r < 40; r++) begin
      w = int'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        st[k] = int'($urandom_range(0, 3));
        dl[k] = int'($urandom_range(1, 4));
        if (TmoEn && $urandom_range(0, 7) == 0) dl[k] = int'($urandom_range(10, 20));
      end
      idle_cycles(w, int'($urandom_range(0, 2)), 1'b1);
      run_dot(w, st, dl, 1'b1, dc, nl, nm, na, nd);
      chk($sformatf("rnd%0d_dones", r), nd, 1);
    end

    // Asynchronous reset in the middle of a MUL phase.
    set_in(0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    chk("midrst_outs0", int'(get_out(0)), 0);
    chk("midrst_outs1", int'(get_out(1)), 0);
    chk("midrst_idx0", get_idx(0), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    last_idx = '{0, 0};
    m_err    = '{1'b0, 1'b0};
    idle_cycles(0, 4, 1'b1);
    idle_cycles(1, 2, 1'b1);
    run_dot(0, '{0, 0, 0, 0}, '{1, 1, 1, 1}, 1'b0, dc, nl, nm, na, nd);
    chk("postrst_done_cyc", dc, 18);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
